// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared defaults and sizing helpers for the LIFO stack
//
// Purpose : default DATA_W/DEPTH/margin values and the occupancy-counter
//           width helper used by lifo_stack_param and lifo_mem.
// Ports   : none (package).
package lifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_MARGIN = 2;
    localparam int DEF_AE_MARGIN = 2;

    // Counter must represent 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Storage address width; DEPTH >= 2 keeps this at least 1.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// rtl/lifo_mem.sv - DEPTH x DATA_W storage array for the LIFO stack
//
// Purpose : plain register array, one synchronous write port and one
//           asynchronous read port. Contents are not reset.
// Ports   : clock    - write clock, rising edge
//           wr_en    - write enable
//           wr_addr  - write address
//           wr_data  - write data
//           rd_addr  - read address (combinational read)
//           rd_data  - read data
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read gives read-before-write on the same entry: the
    // value seen this cycle is the one stored before the edge.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack_param.sv
// rtl/lifo_stack_param.sv - parametrised synchronous LIFO with flags and flush
//
// Purpose : stack with occupancy count, almost-full/almost-empty flags,
//           flush, same-cycle push+pop replace-top and a registered pop
//           output with a one-cycle valid strobe.
// Option  : define LIFO_ERR_FLAGS_EN to add sticky overflow/underflow
//           flags and their err_clr input.
// Ports   : clock        - system clock, rising edge
//           resetn       - asynchronous active-low reset
//           flush        - synchronous clear of stack contents
//           push, pop    - write / read requests
//           data_in      - push data
//           data_out     - last popped word (registered, held)
//           rd_valid     - data_out updated this cycle
//           empty, full, almost_full, almost_empty - occupancy flags
//           count        - occupancy 0..DEPTH
//           err_clr, overflow, underflow - only with LIFO_ERR_FLAGS_EN
module lifo_stack_param
    import lifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_MARGIN = DEF_AF_MARGIN,
    parameter int AE_MARGIN = DEF_AE_MARGIN,
    parameter int CNT_W     = cnt_width(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count
`ifdef LIFO_ERR_FLAGS_EN
    ,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int ADDR_W = addr_width(DEPTH);

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] top_addr;
    logic [DATA_W-1:0] top_data;
    logic [CNT_W-1:0]  count_nxt;
    logic              load_out;
    logic              valid_nxt;

    // Flags are decoded from the count alone.
    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign almost_full  = (int'(count) >= (DEPTH - AF_MARGIN));
    assign almost_empty = (int'(count) <= AE_MARGIN);

    // Top of stack is mem[count-1]; park the address at 0 when empty so
    // the read index always stays inside the array.
    assign top_addr = empty ? '0 : ADDR_W'(count - CNT_W'(1));

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_we),
        .wr_addr (mem_waddr),
        .wr_data (data_in),
        .rd_addr (top_addr),
        .rd_data (top_data)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ADDR_W'(count);
        count_nxt = count;
        load_out  = 1'b0;
        valid_nxt = 1'b0;
        if (flush) begin
            count_nxt = '0;
        end else if (push && pop) begin
            mem_we = 1'b1;
            if (empty) begin
                // Nothing to pop: the push still lands in slot 0.
                mem_waddr = '0;
                count_nxt = CNT_W'(1);
            end else begin
                // Replace-top: old top goes out, new word takes its slot.
                mem_waddr = top_addr;
                load_out  = 1'b1;
                valid_nxt = 1'b1;
            end
        end else if (push) begin
            if (!full) begin
                mem_we    = 1'b1;
                count_nxt = count + CNT_W'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                load_out  = 1'b1;
                valid_nxt = 1'b1;
                count_nxt = count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            rd_valid <= 1'b0;
            data_out <= '0;
        end else begin
            count    <= count_nxt;
            rd_valid <= valid_nxt;
            if (load_out) begin
                data_out <= top_data;
            end
        end
    end

`ifdef LIFO_ERR_FLAGS_EN
    logic ovf_evt;
    logic udf_evt;

    // Underflow covers both a lone pop and a push+pop on an empty stack.
    assign ovf_evt = !flush && push && !pop && full;
    assign udf_evt = !flush && pop && empty;

    // Sticky flags: a new event wins over a clear in the same cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/lifo_stack_param.md
Name: lifo_stack_param

Overview:
Parametrised synchronous LIFO (stack) with configurable data width and depth, occupancy count, almost-full/almost-empty flags, flush, and same-cycle push/pop replace-top. It is the next-generation stack for the datapath buffering layer: one clock, registered pop data with a valid strobe, and defined behaviour for every full/empty corner.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2; need not be a power of two)
AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN
AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of stack contents
push  in  1  write request
pop  in  1  read request
data_in  in  DATA_W  push data
data_out  out  DATA_W  popped word, registered
rd_valid  out  1  one-cycle strobe, data_out updated this cycle
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  see AF_MARGIN
almost_empty  out  1  see AE_MARGIN
count  out  CNT_W  occupancy, CNT_W = $clog2(DEPTH+1)

Behaviour:
- Reset (resetn low, asynchronous assert, synchronous release): count=0, data_out=0, rd_valid=0, error flags=0; empty=1, full=0, almost_empty=1, almost_full=0. Memory contents not reset.
- Flags combinational from count only; never from pointer compare.
- Stack pointer equals count; top of stack is mem[count-1]; pointer never wraps.
- Priority per cycle: flush > push/pop.
- flush=1: count<=0, rd_valid<=0, data_out held; push/pop that cycle ignored.
- push only, !full: mem[count]<=data_in, count+1.
- push only, full: dropped, count unchanged, overflow event.
- pop only, !empty: data_out<=mem[count-1], rd_valid<=1 next cycle, count-1.
- pop only, empty: ignored, data_out held, rd_valid<=0, underflow event.
- push & pop, !empty (incl. full): replace-top; data_out<=old mem[count-1], mem[count-1]<=data_in, rd_valid<=1, count unchanged.
- push & pop, empty: push performed (count becomes 1), pop ignored, rd_valid<=0, underflow event.
- Pop latency: 1 cycle; data_out and rd_valid registered. data_out holds last popped value until next accepted pop.
- Read uses pre-update memory (read-before-write on same entry).

Optional Feature:
LIFO_ERR_FLAGS_EN: defined -> adds ports err_clr (in, 1), overflow (out, 1), underflow (out, 1); flags are sticky, set on the events above, cleared by err_clr or reset; set has priority over clear in the same cycle. Undefined -> ports absent, events silently ignored, no extra logic.

Decomposition:
- Package lifo_pkg: CNT_W function/constant helper, default DATA_W/DEPTH, margin defaults.
- Sub-module lifo_mem: DEPTH x DATA_W array, one synchronous write port, one asynchronous read port; no reset. Top holds count, control, flags, output register.

Test Plan:
- Reset then 16 pushes 0x01..0x10 (DEPTH=16) -> full=1 after 16th, count=16, almost_full from count=14; 17th push 0xFF dropped, overflow=1 (macro on).
- From full, 16 pops -> data_out 0x10,0x0F..0x01 each one cycle after pop with rd_valid=1; empty=1 after last; extra pop -> rd_valid=0, data_out stays 0x01, underflow=1.
- Push 0xA1,0xA2 then push 0xB0 & pop same cycle -> data_out=0xA2, count=2; next pop -> 0xB0.
- Empty stack, push 0x55 & pop together -> count=1, rd_valid=0, underflow set; pop -> 0x55.
- Push 5 words, assert flush with push -> count=0, empty=1, pushed word discarded; following pop -> underflow, no rd_valid.
- Assert resetn low mid-burst asynchronously (between edges) -> count=0, rd_valid=0, data_out=0 immediately; DEPTH=5, DATA_W=12 rerun of first two scenarios passes.
